// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard and stall controller.
// The mult/div occupancy FSM encoding lives here so every block agrees on it.
package hazard_stall_ctrl_pkg;

    localparam int MULDIV_CYCLES_DEF = 4;
    localparam int REG_FIELD_W       = 5;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous reset and count enable.
// Holds at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use and HI/LO stalls, branch flushes,
// PC/IF-ID enables and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int STALLCNT_W    = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   IDValid,
    input  logic [REG_FIELD_W-1:0] IDRsField,
    input  logic [REG_FIELD_W-1:0] IDRtField,
    input  logic                   IDUsesRt,
    input  logic                   IDHiLoOp,
    input  logic                   EXMemRead,
    input  logic [REG_FIELD_W-1:0] EXRTField,
    input  logic                   EXMulDivStart,
    input  logic                   BranchTaken,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IFIDFlush,
    output logic                   IDEXFlush,
    output logic                   EXMEMFlush,
    output logic                   MulDivBusy,
    output logic [STALLCNT_W-1:0]  StallCycles
);

    localparam int               CNT_W      = $clog2(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_busy_cnt;
    logic [CNT_W-1:0] w_busy_cnt_nxt;
    logic             w_md_start;
    logic             w_busy;
    logic             w_load_use;
    logic             w_md_stall;
    logic             w_stall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= RUN;
            r_busy_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    // A start arriving with a taken branch belongs to a flushed instruction.
    assign w_md_start = EXMulDivStart & ~BranchTaken;

    always_comb begin
        w_state_nxt    = r_state;
        w_busy_cnt_nxt = r_busy_cnt;
        case (r_state)
            RUN: begin
                if (w_md_start) begin
                    w_state_nxt    = MD_BUSY;
                    w_busy_cnt_nxt = CNT_RELOAD;
                end
            end
            MD_BUSY: begin
                if (w_md_start) begin
                    w_busy_cnt_nxt = CNT_RELOAD;
                end else if (r_busy_cnt == CNT_ONE) begin
                    w_state_nxt    = RUN;
                    w_busy_cnt_nxt = '0;
                end else begin
                    w_busy_cnt_nxt = r_busy_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_busy_cnt_nxt = '0;
            end
        endcase
    end

    assign w_busy     = (r_state == MD_BUSY);
    assign w_load_use = IDValid & EXMemRead & (EXRTField != '0) &
                        ((EXRTField == IDRsField) | (IDUsesRt & (EXRTField == IDRtField)));
    assign w_md_stall = w_busy & IDValid & IDHiLoOp;
    assign w_stall    = (w_load_use | w_md_stall) & ~BranchTaken;

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        MulDivBusy = w_busy;
        if (Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
            MulDivBusy = 1'b0;
        end else if (BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (w_stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXFlush  = 1'b1;
        end
    end

    hazard_sat_counter #(
        .WIDTH (STALLCNT_W)
    ) u_stall_cnt (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_en    (w_stall & ~Reset),
        .o_count (StallCycles)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a queue-based scoreboard fed by
// a reference model of the controller's external behaviour.
module tb_hazard_stall_ctrl;

    logic       Clk;
    logic       Reset;
    logic       IDValid;
    logic [4:0] IDRsField;
    logic [4:0] IDRtField;
    logic       IDUsesRt;
    logic       IDHiLoOp;
    logic       EXMemRead;
    logic [4:0] EXRTField;
    logic       EXMulDivStart;
    logic       BranchTaken;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IFIDFlush;
    logic       IDEXFlush;
    logic       EXMEMFlush;
    logic       MulDivBusy;
    logic [3:0] StallCycles;

    typedef struct packed {
        logic [5:0] ctrl;
        logic [3:0] sc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state
    logic m_busy = 1'b0;
    int   m_cnt  = 0;
    int   m_sc   = 0;

    hazard_stall_ctrl #(
        .MULDIV_CYCLES (4),
        .STALLCNT_W    (4)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .IDValid       (IDValid),
        .IDRsField     (IDRsField),
        .IDRtField     (IDRtField),
        .IDUsesRt      (IDUsesRt),
        .IDHiLoOp      (IDHiLoOp),
        .EXMemRead     (EXMemRead),
        .EXRTField     (EXRTField),
        .EXMulDivStart (EXMulDivStart),
        .BranchTaken   (BranchTaken),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IFIDFlush     (IFIDFlush),
        .IDEXFlush     (IDEXFlush),
        .EXMEMFlush    (EXMEMFlush),
        .MulDivBusy    (MulDivBusy),
        .StallCycles   (StallCycles)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic model_hazard();
        logic lu;
        logic md;
        lu = IDValid & EXMemRead & (EXRTField != 5'd0) &
             ((EXRTField == IDRsField) | (IDUsesRt & (EXRTField == IDRtField)));
        md = m_busy & IDValid & IDHiLoOp;
        return lu | md;
    endfunction

    // ctrl order: PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MulDivBusy
    function automatic exp_t model_expect();
        exp_t e;
        e.sc = 4'(m_sc);
        if (Reset)              e.ctrl = {5'b00111, 1'b0};
        else if (BranchTaken)   e.ctrl = {5'b11111, m_busy};
        else if (model_hazard()) e.ctrl = {5'b00010, m_busy};
        else                    e.ctrl = {5'b11000, m_busy};
        return e;
    endfunction

    task automatic model_advance();
        logic stall;
        stall = model_hazard() & ~BranchTaken;
        if (Reset) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_sc   = 0;
        end else begin
            if (stall && m_sc < 15) m_sc = m_sc + 1;
            if (EXMulDivStart && !BranchTaken) begin
                m_busy = 1'b1;
                m_cnt  = 3;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        sb_q.push_back(model_expect());
        @(negedge Clk);
        e = sb_q.pop_front();
        n_cmp++;
        assert ({PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MulDivBusy} === e.ctrl)
        else begin
            n_fail++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag,
                   {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MulDivBusy}, e.ctrl);
        end
        n_cmp++;
        assert (StallCycles === e.sc)
        else begin
            n_fail++;
            $error("FAIL %s StallCycles observed=%0d expected=%0d", tag, StallCycles, e.sc);
        end
        model_advance();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_sc(input string tag, input logic [3:0] want);
        n_cmp++;
        assert (StallCycles === want)
        else begin
            n_fail++;
            $error("FAIL %s StallCycles observed=%0d expected=%0d", tag, StallCycles, want);
        end
    endtask

    task automatic clear_inputs();
        IDValid       = 1'b0;
        IDRsField     = 5'd0;
        IDRtField     = 5'd0;
        IDUsesRt      = 1'b0;
        IDHiLoOp      = 1'b0;
        EXMemRead     = 1'b0;
        EXRTField     = 5'd0;
        EXMulDivStart = 1'b0;
        BranchTaken   = 1'b0;
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        step("rst_idle");
        Reset = 1'b0;
        step("run_idle");

        // reset in the middle of a mult/div occupancy
        EXMulDivStart = 1'b1;
        step("md_start0");
        EXMulDivStart = 1'b0;
        step("md_busy_a");
        Reset = 1'b1;
        repeat (3) step("rst_mid_md");
        Reset = 1'b0;
        step("post_rst");
        check_sc("post_rst_sc", 4'd0);

        // load-use on rs
        IDValid = 1'b1; EXMemRead = 1'b1; EXRTField = 5'd8; IDRsField = 5'd8;
        step("lu_rs");
        EXMemRead = 1'b0;
        step("lu_clear");
        check_sc("lu_rs_sc", 4'd1);

        // register 0, rt without use, rt with use, invalid ID
        EXMemRead = 1'b1; EXRTField = 5'd0; IDRsField = 5'd0;
        step("lu_r0");
        EXRTField = 5'd9; IDRsField = 5'd3; IDRtField = 5'd9; IDUsesRt = 1'b0;
        step("rt_nouse");
        IDUsesRt = 1'b1;
        step("rt_use");
        IDValid = 1'b0;
        step("lu_invalid");
        clear_inputs();

        // HI/LO consumer waiting on a 4-cycle mult/div
        EXMulDivStart = 1'b1; IDValid = 1'b1;
        step("md_start1");
        EXMulDivStart = 1'b0; IDHiLoOp = 1'b1;
        repeat (4) step("md_hilo");
        check_sc("md_hilo_sc", 4'd5);
        clear_inputs();

        // taken branch overrides hazards while mult/div keeps counting
        EXMulDivStart = 1'b1;
        step("md_start2");
        EXMulDivStart = 1'b0;
        IDValid = 1'b1; EXMemRead = 1'b1; EXRTField = 5'd8; IDRsField = 5'd8;
        IDHiLoOp = 1'b1; BranchTaken = 1'b1;
        step("br_hazard");
        clear_inputs();
        step("md_after_br");
        step("md_end");
        check_sc("br_sc", 4'd5);

        // start on a flushed instruction is ignored
        EXMulDivStart = 1'b1; BranchTaken = 1'b1;
        step("br_start");
        clear_inputs();
        step("br_start_idle");

        // saturation
        IDValid = 1'b1; EXMemRead = 1'b1; EXRTField = 5'd8; IDRsField = 5'd8;
        repeat (20) step("lu_sat");
        clear_inputs();
        step("sat_hold");
        check_sc("sat_sc", 4'd15);

        Reset = 1'b1;
        step("final_rst");
        Reset = 1'b0;
        step("final_run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
